// File: rtl/can_acf_pkg.sv
// can_acf_pkg: shared state type, sizes and the ID comparator for the acceptance filter
package can_acf_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, WRITE} acf_state_t;
  localparam int MAX_FILTERS = 4;
  localparam int ID_W = 32;
  function automatic logic acf_match(input logic [ID_W-1:0] id, input logic [ID_W-1:0] afmr,
                                     input logic [ID_W-1:0] afir, input logic uaf);
    return uaf & ((id & afmr) == (afir & afmr));
  endfunction
endpackage

// File: rtl/can_acf_scheduler.sv
// can_acf_scheduler: latches RX messages and scans one filter per cycle before writing the RX FIFO
module can_acf_scheduler
  import can_acf_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int MSG_W = 128
) (
  input  logic                              i_sys_clk,
  input  logic                              i_reset_n,
  input  logic                              i_msg_valid,
  input  logic [MSG_W-1:0]                  i_rx_message,
  input  logic [MAX_FILTERS-1:0]            i_uaf,
  input  logic [MAX_FILTERS-1:0][ID_W-1:0]  i_afmr,
  input  logic [MAX_FILTERS-1:0][ID_W-1:0]  i_afir,
  input  logic                              i_rx_full,
  output logic                              o_rx_w_en,
  output logic [MSG_W-1:0]                  o_rx_fifo_w_data,
  output logic                              o_acfbsy,
  output logic                              o_msg_dropped,
  output logic                              o_rx_overflow,
  output logic                              o_msg_lost
);
  localparam logic [MAX_FILTERS-1:0] EN_MASK = MAX_FILTERS'((1 << NUM_FILTERS) - 1);
  localparam logic [1:0] LAST = 2'((NUM_FILTERS == 0) ? 0 : NUM_FILTERS - 1);
  acf_state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic hit;
  assign hit = acf_match(msg_q[MSG_W-1 -: ID_W], i_afmr[idx_q], i_afir[idx_q], i_uaf[idx_q]);
  assign o_rx_fifo_w_data = msg_q;
  assign o_acfbsy = state_q != IDLE;
  assign o_msg_lost = i_msg_valid & (state_q != IDLE);
  // state, filter index and latched message
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      msg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      msg_q <= msg_d;
    end
  end
  // next state and status pulses; no enabled filter means accept every message
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    msg_d = msg_q;
    o_rx_w_en = 1'b0;
    o_msg_dropped = 1'b0;
    o_rx_overflow = 1'b0;
    case (state_q)
      IDLE: if (i_msg_valid) begin
        msg_d = i_rx_message;
        idx_d = '0;
        state_d = |(i_uaf & EN_MASK) ? SCAN : WRITE;
      end
      SCAN: if (hit) state_d = WRITE;
      else if (idx_q == LAST) begin
        o_msg_dropped = 1'b1;
        state_d = IDLE;
      end else idx_d = idx_q + 2'd1;
      WRITE: begin
        o_rx_w_en = !i_rx_full;
        o_rx_overflow = i_rx_full;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
